// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared encodings and helpers for the MMIO bus master.
//   SIZE_*   : request size encodings (byte / half / word; 3 is illegal)
//   state_e  : bus master FSM states
//   word_addr: clears the byte-offset bits to form the bus word address
package mem_bus_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the MMIO bus.
//   size, offset, uns : access size, addr[1:0], zero-extend flag
//   store_data        : right-justified store data
//   raw_rdata         : word read back from the device
//   wdata, wstrb      : lane-replicated store data and byte enables
//   load_data         : extracted and extended load data
//   misalign          : illegal size or misaligned address
module mem_lane_align
    import mem_bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    input  logic [31:0] store_data,
    input  logic [31:0] raw_rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = raw_rdata[{offset, 3'b000} +: 8];
    assign rd_half = raw_rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        wdata     = '0;
        wstrb     = '0;
        load_data = '0;
        misalign  = 1'b0;
        case (size)
            SIZE_B: begin
                wdata     = {4{store_data[7:0]}};
                wstrb     = 4'b0001 << offset;
                load_data = uns ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            SIZE_H: begin
                wdata     = {2{store_data[15:0]}};
                wstrb     = 4'b0011 << offset;
                load_data = uns ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
                misalign  = offset[0];
            end
            SIZE_W: begin
                wdata     = store_data;
                wstrb     = 4'hF;
                load_data = raw_rdata;
                misalign  = (offset != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-outstanding load/store initiator for the MMIO bus.
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : valid/ready request from the memory stage
//   resp_*              : valid/ready response (data + error)
//   bus_addr/ren/rdata  : device read side, rdata sampled RD_LAT cycles
//                         after the first bus_ren cycle
//   bus_wdata/wen/wstrb : device write side, one-cycle write strobe
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] bus_addr,
    output logic        bus_ren,
    input  logic [31:0] bus_rdata,
    output logic [31:0] bus_wdata,
    output logic        bus_wen,
    output logic [3:0]  bus_wstrb
);

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_e      state;
    logic [1:0]  cnt;
    logic [1:0]  l_size;
    logic [1:0]  l_off;
    logic        l_uns;

    logic [1:0]  a_size;
    logic [1:0]  a_off;
    logic        a_uns;
    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic [31:0] al_load;
    logic        al_err;

    // One aligner serves both phases: live request fields while idle (store
    // lanes, legality), latched fields afterwards (load extraction).
    assign a_size = (state == ST_IDLE) ? req_size       : l_size;
    assign a_off  = (state == ST_IDLE) ? req_addr[1:0]  : l_off;
    assign a_uns  = (state == ST_IDLE) ? req_unsigned   : l_uns;

    mem_lane_align u_align (
        .size       (a_size),
        .offset     (a_off),
        .uns        (a_uns),
        .store_data (req_wdata),
        .raw_rdata  (bus_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_data  (al_load),
        .misalign   (al_err)
    );

    assign req_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            l_size     <= '0;
            l_off      <= '0;
            l_uns      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            bus_addr   <= '0;
            bus_ren    <= 1'b0;
            bus_wdata  <= '0;
            bus_wen    <= 1'b0;
            bus_wstrb  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        l_size <= req_size;
                        l_off  <= req_addr[1:0];
                        l_uns  <= req_unsigned;
                        cnt    <= '0;
                        if (al_err) begin
                            // illegal requests never touch the bus
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= ST_RESP;
                        end else begin
                            bus_addr <= word_addr(req_addr);
                            if (req_we) begin
                                bus_wen   <= 1'b1;
                                bus_wdata <= al_wdata;
                                bus_wstrb <= al_wstrb;
                                state     <= ST_WRITE;
                            end else begin
                                bus_ren <= 1'b1;
                                state   <= ST_READ;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    bus_wen    <= 1'b0;
                    bus_wdata  <= '0;
                    bus_wstrb  <= '0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= ST_RESP;
                end
                ST_READ: begin
                    if (cnt == LAT) begin
                        bus_ren    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= al_load;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed checks of mem_bus_master. dut1 runs with
// RD_LAT=1, dut3 with RD_LAT=3 (own rst/req_valid/resp_ready). Inputs are
// driven and outputs sampled 1ns after each rising edge.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        rst, rst3;
    logic        req_valid, req_valid3;
    logic        req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, bus_rdata;
    logic        resp_ready, resp_ready3;

    logic        r1_ready, r1_valid, r1_err, b1_ren, b1_wen;
    logic [31:0] r1_rdata, b1_addr, b1_wdata;
    logic [3:0]  b1_wstrb;
    logic        r3_ready, r3_valid, r3_err, b3_ren, b3_wen;
    logic [31:0] r3_rdata, b3_addr, b3_wdata;
    logic [3:0]  b3_wstrb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_master #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r1_valid),
        .resp_ready(resp_ready), .resp_rdata(r1_rdata), .resp_err(r1_err),
        .bus_addr(b1_addr), .bus_ren(b1_ren), .bus_rdata(bus_rdata),
        .bus_wdata(b1_wdata), .bus_wen(b1_wen), .bus_wstrb(b1_wstrb)
    );

    mem_bus_master #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(r3_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r3_valid),
        .resp_ready(resp_ready3), .resp_rdata(r3_rdata), .resp_err(r3_err),
        .bus_addr(b3_addr), .bus_ren(b3_ren), .bus_rdata(bus_rdata),
        .bus_wdata(b3_wdata), .bus_wen(b3_wen), .bus_wstrb(b3_wstrb)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request to dut1 for one edge; returns at the T+1 sample point.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for a dut1 response, return it and complete the handshake.
    task automatic take_resp(input string tag, output logic [31:0] d, output logic e);
        for (int i = 0; i < 12 && !r1_valid; i++) tick;
        chk({tag, "_resp_seen"}, {31'b0, r1_valid}, 32'd1);
        d = r1_rdata;
        e = r1_err;
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
    endtask

    logic [31:0] d;
    logic        e;
    logic        saw_ren, saw_wen, saw_resp;

    initial begin
        rst = 1'b1; rst3 = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; bus_rdata = '0;
        resp_ready = 1'b0; resp_ready3 = 1'b0;
        tick; tick;
        // reset state
        chk("rst_req_ready", {31'b0, r1_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, r1_valid}, 32'd0);
        chk("rst_bus_ren", {31'b0, b1_ren}, 32'd0);
        chk("rst_bus_wen", {31'b0, b1_wen}, 32'd0);
        chk("rst_bus_addr", b1_addr, 32'd0);
        chk("rst_bus_wstrb", {28'b0, b1_wstrb}, 32'd0);
        rst = 1'b0; rst3 = 1'b0;
        tick;

        // byte store at 0x5
        issue(1'b1, 2'd0, 1'b0, 32'h0000_0005, 32'h0000_00AB);
        chk("sb_wen_t1", {31'b0, b1_wen}, 32'd1);
        chk("sb_addr_t1", b1_addr, 32'h4);
        chk("sb_wdata_t1", b1_wdata, 32'hABABABAB);
        chk("sb_wstrb_t1", {28'b0, b1_wstrb}, 32'b0010);
        chk("sb_ready_t1", {31'b0, r1_ready}, 32'd0);
        chk("sb_resp_t1", {31'b0, r1_valid}, 32'd0);
        tick;
        chk("sb_resp_t2", {31'b0, r1_valid}, 32'd1);
        chk("sb_err_t2", {31'b0, r1_err}, 32'd0);
        chk("sb_wen_t2", {31'b0, b1_wen}, 32'd0);
        chk("sb_wstrb_t2", {28'b0, b1_wstrb}, 32'd0);
        chk("sb_wdata_t2", b1_wdata, 32'd0);
        resp_ready = 1'b1; tick; resp_ready = 1'b0;
        chk("sb_resp_done", {31'b0, r1_valid}, 32'd0);
        chk("sb_idle", {31'b0, r1_ready}, 32'd1);
        chk("sb_addr_hold", b1_addr, 32'h4);

        // half and word stores
        issue(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_BEEF);
        chk("sh_wdata", b1_wdata, 32'hBEEFBEEF);
        chk("sh_wstrb", {28'b0, b1_wstrb}, 32'b1100);
        chk("sh_addr", b1_addr, 32'h100);
        take_resp("sh", d, e);
        chk("sh_err", {31'b0, e}, 32'd0);
        tick;
        issue(1'b1, 2'd2, 1'b0, 32'h0000_000C, 32'hDEADBEEF);
        chk("sw_wdata", b1_wdata, 32'hDEADBEEF);
        chk("sw_wstrb", {28'b0, b1_wstrb}, 32'hF);
        take_resp("sw", d, e);
        tick;

        // word load, RD_LAT=1: ren at T+1,T+2, response at T+3
        bus_rdata = 32'h12345678;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0);
        chk("lw_ren_t1", {31'b0, b1_ren}, 32'd1);
        chk("lw_addr_t1", b1_addr, 32'h8);
        tick;
        chk("lw_ren_t2", {31'b0, b1_ren}, 32'd1);
        chk("lw_resp_t2", {31'b0, r1_valid}, 32'd0);
        tick;
        chk("lw_resp_t3", {31'b0, r1_valid}, 32'd1);
        chk("lw_data_t3", r1_rdata, 32'h12345678);
        chk("lw_ren_t3", {31'b0, b1_ren}, 32'd0);
        resp_ready = 1'b1; tick; resp_ready = 1'b0;
        tick;

        // byte / half extraction and extension
        bus_rdata = 32'h0080FF00;
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0006, 32'h0);
        take_resp("lb_s", d, e);
        chk("lb_signed", d, 32'hFFFFFF80);
        tick;
        issue(1'b0, 2'd0, 1'b1, 32'h0000_0006, 32'h0);
        take_resp("lb_u", d, e);
        chk("lb_unsigned", d, 32'h00000080);
        tick;
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0005, 32'h0);
        take_resp("lb_s1", d, e);
        chk("lb_signed_off1", d, 32'hFFFFFFFF);
        tick;
        bus_rdata = 32'h8001_0000;
        issue(1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0);
        take_resp("lh_s", d, e);
        chk("lh_signed", d, 32'hFFFF8001);
        tick;
        bus_rdata = 32'h8001_9234;
        issue(1'b0, 2'd1, 1'b1, 32'h0000_0000, 32'h0);
        take_resp("lh_u", d, e);
        chk("lh_unsigned_low", d, 32'h00009234);
        tick;

        // misaligned half load at 0x3: error at T+1, no bus activity
        saw_ren = 1'b0; saw_wen = 1'b0;
        issue(1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0);
        chk("mis_resp_t1", {31'b0, r1_valid}, 32'd1);
        chk("mis_err_t1", {31'b0, r1_err}, 32'd1);
        chk("mis_data_t1", r1_rdata, 32'd0);
        saw_ren = b1_ren; saw_wen = b1_wen;
        resp_ready = 1'b1; tick; resp_ready = 1'b0;
        saw_ren |= b1_ren; saw_wen |= b1_wen;
        tick;
        // misaligned word store and illegal size
        issue(1'b1, 2'd2, 1'b0, 32'h0000_0002, 32'h55);
        saw_ren |= b1_ren; saw_wen |= b1_wen;
        chk("mis_sw_err", {31'b0, r1_err}, 32'd1);
        resp_ready = 1'b1; tick; resp_ready = 1'b0;
        tick;
        issue(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0);
        saw_ren |= b1_ren; saw_wen |= b1_wen;
        chk("size3_err", {31'b0, r1_err}, 32'd1);
        chk("size3_resp", {31'b0, r1_valid}, 32'd1);
        resp_ready = 1'b1; tick; resp_ready = 1'b0;
        chk("mis_no_strobes", {30'b0, saw_ren, saw_wen}, 32'd0);
        tick;

        // backpressure with a second request pending
        bus_rdata = 32'hCAFEF00D;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
        tick; tick;
        chk("bp_resp", {31'b0, r1_valid}, 32'd1);
        chk("bp_data", r1_rdata, 32'hCAFEF00D);
        req_we = 1'b1; req_size = 2'd0; req_addr = 32'h0000_0021;
        req_wdata = 32'h0000_005A; req_valid = 1'b1;
        bus_rdata = 32'h0BAD0BAD;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("bp_hold_valid", {31'b0, r1_valid}, 32'd1);
            chk("bp_hold_data", r1_rdata, 32'hCAFEF00D);
            chk("bp_hold_err", {31'b0, r1_err}, 32'd0);
            chk("bp_hold_ready", {31'b0, r1_ready}, 32'd0);
            chk("bp_hold_wen", {31'b0, b1_wen}, 32'd0);
        end
        resp_ready = 1'b1; tick; resp_ready = 1'b0;
        chk("bp_released", {31'b0, r1_valid}, 32'd0);
        chk("bp_idle", {31'b0, r1_ready}, 32'd1);
        chk("bp_not_yet", {31'b0, b1_wen}, 32'd0);
        tick;
        req_valid = 1'b0;
        chk("bp2_wen", {31'b0, b1_wen}, 32'd1);
        chk("bp2_wdata", b1_wdata, 32'h5A5A5A5A);
        chk("bp2_wstrb", {28'b0, b1_wstrb}, 32'b0010);
        chk("bp2_addr", b1_addr, 32'h20);
        take_resp("bp2", d, e);
        tick;

        // RD_LAT=3 full load: ren T+1..T+4, response at T+5
        bus_rdata = 32'hA5A5_0001;
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_0040; req_valid3 = 1'b1;
        tick;
        req_valid3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("l3_ren", {31'b0, b3_ren}, 32'd1);
            chk("l3_no_resp", {31'b0, r3_valid}, 32'd0);
            tick;
        end
        chk("l3_resp", {31'b0, r3_valid}, 32'd1);
        chk("l3_data", r3_rdata, 32'hA5A50001);
        chk("l3_ren_off", {31'b0, b3_ren}, 32'd0);
        resp_ready3 = 1'b1; tick; resp_ready3 = 1'b0;
        tick;

        // reset during the second READ cycle drops the load
        req_addr = 32'h0000_0044; req_valid3 = 1'b1;
        tick;
        req_valid3 = 1'b0;
        chk("rr_ren_c1", {31'b0, b3_ren}, 32'd1);
        tick;
        chk("rr_ren_c2", {31'b0, b3_ren}, 32'd1);
        rst3 = 1'b1;
        tick;
        rst3 = 1'b0;
        chk("rr_ren_low", {31'b0, b3_ren}, 32'd0);
        chk("rr_ready", {31'b0, r3_ready}, 32'd1);
        saw_resp = r3_valid;
        for (int i = 0; i < 6; i++) begin
            tick;
            saw_resp |= r3_valid;
        end
        chk("rr_no_resp", {31'b0, saw_resp}, 32'd0);
        chk("rr_idle_after", {31'b0, r3_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
